spi_ram_ctrl: RTL
=================

SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the address register width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the word width, with ADDR_WIDTH <= DATA_WIDTH.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, giving the word count, with MEM_DEPTH <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter AUTO_INC, default 1, where 1 enables address post-increment after data operations.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-007 The block SHALL have port din, input, DATA_WIDTH+2 bits: the command word, where [DATA_WIDTH+1:DATA_WIDTH] is the opcode and [DATA_WIDTH-1:0] is the payload.
REQ-008 The block SHALL have port rx_valid, input, 1 bit: din is valid.
REQ-009 The block SHALL have port rx_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port dout, output, DATA_WIDTH bits: read data.
REQ-011 The block SHALL have port tx_valid, output, 1 bit: dout holds valid read data.
REQ-012 The block SHALL have port tx_ready, input, 1 bit: the consumer takes dout.
REQ-013 The block SHALL have port addr_err, output, 1 bit: sticky out-of-range access flag.

Function
REQ-014 A command SHALL be accepted on a rising edge only when rx_valid=1 and rx_ready=1; otherwise din SHALL be ignored.
REQ-015 Opcode 00 (WR_ADDR) SHALL load wr_add with payload[ADDR_WIDTH-1:0].
REQ-016 Opcode 01 (WR_DATA) SHALL write payload to MEM[wr_add] when wr_add < MEM_DEPTH, and SHALL otherwise leave memory unchanged and set addr_err.
REQ-017 Opcode 10 (RD_ADDR) SHALL load rd_add with payload[ADDR_WIDTH-1:0].
REQ-018 Opcode 11 (RD_DATA) SHALL load dout with MEM[rd_add], or with 0 plus addr_err set when rd_add >= MEM_DEPTH, and SHALL move the FSM from IDLE to HOLD.
REQ-019 The read latency SHALL be one cycle: when RD_DATA is accepted at edge N, dout and tx_valid SHALL be valid after edge N.
REQ-020 The FSM SHALL have two states: IDLE (tx_valid=0, rx_ready=1) and HOLD (tx_valid=1, rx_ready=0).
REQ-021 The FSM SHALL leave HOLD for IDLE on the edge where tx_ready=1, SHALL otherwise remain in HOLD, and dout SHALL be stable while in HOLD.
REQ-022 The read handshake SHALL take a minimum of two cycles per read, and no command SHALL be accepted in HOLD.
REQ-023 With AUTO_INC=1, wr_add SHALL increment after every WR_DATA and rd_add SHALL increment after every RD_DATA, in both cases including out-of-range accesses.
REQ-024 An incremented address equal to MEM_DEPTH-1 SHALL wrap to 0; an address already >= MEM_DEPTH SHALL increment modulo 2**ADDR_WIDTH.
REQ-025 With AUTO_INC=0, addresses SHALL change only on WR_ADDR or RD_ADDR.
REQ-026 RD_DATA accepted the cycle after a WR_DATA to the same address SHALL return the newly written word.
REQ-027 wr_add and rd_add SHALL be independent, and writes SHALL never disturb a dout held in HOLD.
REQ-028 Payload bits above ADDR_WIDTH-1 SHALL be ignored for address opcodes.
REQ-029 addr_err SHALL remain set until reset.

Reset
REQ-030 While rst=1 at an edge: the FSM SHALL go to IDLE, tx_valid=0, rx_ready=1 (combinational from the state), dout=0, wr_add=0, rd_add=0, addr_err=0.
REQ-031 Reset SHALL take priority over all commands and handshakes, including during HOLD, where the pending read data is discarded.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 The bench SHALL cover single write/read: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA with tx_ready=1 -> dout=0xA5 with tx_valid high exactly one cycle, one cycle after RD_DATA acceptance.
REQ-034 The bench SHALL cover backpressure: RD_DATA with tx_ready=0 for 5 cycles -> tx_valid and dout stable, rx_ready=0, a WR_DATA presented meanwhile ignored (memory unchanged); tx_ready=1 -> IDLE next cycle.
REQ-035 The bench SHALL cover auto-increment wrap with MEM_DEPTH=256: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33 -> MEM[0xFE]=0x11, MEM[0xFF]=0x22, MEM[0x00]=0x33; sequential burst reads return the same values.
REQ-036 The bench SHALL cover out-of-range with MEM_DEPTH=200: WR_ADDR 0xD0, WR_DATA 0x55 -> no write, addr_err=1; RD_ADDR 0xD0, RD_DATA -> dout=0.
REQ-037 The bench SHALL cover reset mid-read: rst=1 during HOLD -> tx_valid=0, dout=0, rx_ready=1, addr_err=0 next cycle; earlier written data still readable.
REQ-038 The bench SHALL cover AUTO_INC=0: two RD_DATA at rd_add 0x05 -> same word twice, rd_add unchanged.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// Command-driven word RAM sitting behind a byte-oriented serial front end.
// Each accepted command word carries a 2-bit opcode and a payload:
//   00 WR_ADDR : load the write address
//   01 WR_DATA : write payload to MEM[wr_add]
//   10 RD_ADDR : load the read address
//   11 RD_DATA : fetch MEM[rd_add] into dout and hold it until taken
// Write and read addresses are independent registers. With AUTO_INC set,
// each data operation post-increments its own address.
//
// Handshakes (both directions use the same rule):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   A producer keeps its data stable while valid=1 and ready=0. Ready never
//   depends combinationally on valid.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   din       : command word {opcode[1:0], payload[DATA_WIDTH-1:0]}
//   rx_valid  : din is valid
//   rx_ready  : block accepts din (high in IDLE)
//   dout      : read data, stable while tx_valid=1
//   tx_valid  : dout holds read data (high in HOLD)
//   tx_ready  : consumer takes dout
//   addr_err  : sticky flag, set by any out-of-range data access
//   dbg_state : current FSM state (0 = IDLE, 1 = HOLD)

module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  addr_err,
  output logic                  dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_add;
  logic [ADDR_WIDTH-1:0] r_rd_add;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_addr_err;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  logic                  w_accept;
  logic [1:0]            w_op;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic [ADDR_WIDTH-1:0] w_wr_inc;
  logic [ADDR_WIDTH-1:0] w_rd_inc;
  logic                  w_mem_we;

  assign w_accept  = rx_valid & rx_ready;
  assign w_op      = din[DATA_WIDTH+1:DATA_WIDTH];
  assign w_payload = din[DATA_WIDTH-1:0];
  // Payload bits above the address width are dropped for address opcodes.
  assign w_addr_in = din[ADDR_WIDTH-1:0];

  assign w_wr_in_range = ({1'b0, r_wr_add} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, r_rd_add} < LP_DEPTH);

  // The last valid word wraps to 0; an address that is already out of
  // range just counts on and wraps naturally at 2**ADDR_WIDTH.
  assign w_wr_inc = (r_wr_add == LP_LAST) ? '0 : r_wr_add + ADDR_WIDTH'(1);
  assign w_rd_inc = (r_rd_add == LP_LAST) ? '0 : r_rd_add + ADDR_WIDTH'(1);

  // Reset outranks commands, so a write presented during reset is dropped.
  assign w_mem_we = ~rst & w_accept & (w_op == OP_WR_DATA) & w_wr_in_range;

  // ---------------------------------------------------------------------
  // Memory array: never reset, so contents survive a controller reset.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_wr_add] <= w_payload;
    end
  end

  // ---------------------------------------------------------------------
  // Controller FSM
  // IDLE accepts any command. RD_DATA captures the word and moves to HOLD,
  // where dout is frozen and no command is accepted until tx_ready=1.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_add   <= '0;
      r_rd_add   <= '0;
      r_dout     <= '0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_WR_ADDR: begin
                r_wr_add <= w_addr_in;
              end
              OP_WR_DATA: begin
                if (!w_wr_in_range) begin
                  r_addr_err <= 1'b1;
                end
                if (AUTO_INC != 0) begin
                  r_wr_add <= w_wr_inc;
                end
              end
              OP_RD_ADDR: begin
                r_rd_add <= w_addr_in;
              end
              OP_RD_DATA: begin
                if (w_rd_in_range) begin
                  r_dout <= r_mem[r_rd_add];
                end else begin
                  r_dout     <= '0;
                  r_addr_err <= 1'b1;
                end
                if (AUTO_INC != 0) begin
                  r_rd_add <= w_rd_inc;
                end
                r_state <= ST_HOLD;
              end
              default: begin
              end
            endcase
          end
        end
        ST_HOLD: begin
          if (tx_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake flags are pure decodes of the registered state.
  assign rx_ready  = (r_state == ST_IDLE);
  assign tx_valid  = (r_state == ST_HOLD);
  assign dout      = r_dout;
  assign addr_err  = r_addr_err;
  assign dbg_state = r_state;

endmodule
